intc_dispatch_ctrl: RTL and testbench

- Sequences delivery of interrupts from the priority interrupt controller (ic) to the processor.
- Takes the controller's winning peripheral id and priority, raises a request to the CPU, and completes the ack handshake.
- Returns a serviced pulse to ic so it can select the next interrupt.
- Tracks nested in-service interrupts on a priority stack, so only a strictly higher priority interrupt can preempt the one currently running.

---
 rtl/intc_pkg.sv | 17 +
 rtl/intc_nest_stack.sv | 57 +++++
 rtl/intc_dispatch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_intc_dispatch_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Definitions shared by the interrupt dispatch controller, its nesting stack and the ic.
package intc_pkg;

    localparam int DEF_NO_OF_PERIPHERALS = 16;
    localparam int DEF_WIDTH             = $clog2(DEF_NO_OF_PERIPHERALS);

    // One-hot dispatch states
    localparam logic [2:0] S_IDLE    = 3'b001;
    localparam logic [2:0] S_SIGNAL  = 3'b010;
    localparam logic [2:0] S_SERVICE = 3'b100;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] id;
        logic [DEF_WIDTH-1:0] prio;
    } stack_entry_t;

endpackage

// File: rtl/intc_nest_stack.sv
// LIFO of in-service interrupt entries; the top entry is the one currently being serviced.
module intc_nest_stack
    import intc_pkg::*;
#(
    parameter int  NEST_DEPTH = 4,
    parameter int  DEPTH_W    = $clog2(NEST_DEPTH + 1),
    parameter type entry_t    = stack_entry_t
) (
    input  logic               pclk_i,
    input  logic               prst_i,
    input  logic               push,
    input  logic               pop,
    input  entry_t             push_data,
    output entry_t             top,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    entry_t             mem [NEST_DEPTH];
    logic [DEPTH_W-1:0] depth_q;

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            depth_q <= '0;
        end else if (push && !full) begin
            depth_q <= depth_q + 1'b1;
        end else if (pop && !empty) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    // Entries carry no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge pclk_i) begin
        if (push && !full) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (depth_q == DEPTH_W'(i)) begin
                    mem[i] <= push_data;
                end
            end
        end
    end

    always_comb begin
        top = mem[0];
        for (int i = 1; i < NEST_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top = mem[i];
            end
        end
    end

    assign depth = depth_q;
    assign full  = (depth_q == DEPTH_W'(NEST_DEPTH));
    assign empty = (depth_q == '0);

endmodule

// File: rtl/intc_dispatch_ctrl.sv
// Sequences interrupt delivery from the ic to the CPU with nested, priority-gated preemption.
// Optional ack timeout is built when INTC_DISPATCH_ACK_TIMEOUT_EN is defined.
module intc_dispatch_ctrl
    import intc_pkg::*;
#(
    parameter int NO_OF_PERIPHERALS = DEF_NO_OF_PERIPHERALS,
    parameter int WIDTH             = $clog2(NO_OF_PERIPHERALS),
    parameter int NEST_DEPTH        = 4,
    parameter int ACK_TIMEOUT       = 32
) (
    input  logic                             pclk_i,
    input  logic                             prst_i,
    input  logic                             irq_valid_i,
    input  logic [WIDTH-1:0]                 irq_id_i,
    input  logic [WIDTH-1:0]                 irq_prio_i,
    output logic                             irq_serviced_o,
    output logic                             cpu_irq_o,
    output logic [WIDTH-1:0]                 cpu_irq_id_o,
    input  logic                             cpu_ack_i,
    input  logic                             cpu_eoi_i,
    output logic [WIDTH-1:0]                 active_prio_o,
    output logic [$clog2(NEST_DEPTH+1)-1:0]  nest_depth_o,
    output logic                             timeout_err_o
);

    localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] id;
        logic [WIDTH-1:0] prio;
    } entry_t;

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [WIDTH-1:0]   cap_id_p0;
    logic [WIDTH-1:0]   cap_prio_p0;
    logic               serviced_p1;
    logic               eligible;
    logic               capture;
    logic               push;
    logic               pop;
    logic               tmo_done;
    logic               tmo_fire;
    entry_t             push_entry;
    entry_t             stack_top;
    logic [DEPTH_W-1:0] stack_depth;
    logic               stack_full;
    logic               stack_empty;

    intc_nest_stack #(
        .NEST_DEPTH (NEST_DEPTH),
        .DEPTH_W    (DEPTH_W),
        .entry_t    (entry_t)
    ) u_stack (
        .pclk_i    (pclk_i),
        .prst_i    (prst_i),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .top       (stack_top),
        .depth     (stack_depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign push_entry.id   = cap_id_p0;
    assign push_entry.prio = cap_prio_p0;

    // Only a strictly higher priority than the running interrupt may preempt it.
    assign eligible = irq_valid_i && !stack_full &&
                      (stack_empty || (irq_prio_i > stack_top.prio));

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (eligible) begin
                    state_d = S_SIGNAL;
                end
            end
            S_SIGNAL: begin
                if (cpu_ack_i) begin
                    state_d = S_SERVICE;
                end else if (tmo_done) begin
                    state_d = stack_empty ? S_IDLE : S_SERVICE;
                end
            end
            S_SERVICE: begin
                // EOI takes the whole cycle; arbitration against the new top waits one cycle.
                if (cpu_eoi_i) begin
                    if (stack_depth == DEPTH_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end else if (eligible) begin
                    state_d = S_SIGNAL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        capture   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        tmo_fire  = 1'b0;
        cpu_irq_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                capture = eligible;
            end
            S_SIGNAL: begin
                cpu_irq_o = 1'b1;
                push      = cpu_ack_i;
                tmo_fire  = !cpu_ack_i && tmo_done;
            end
            S_SERVICE: begin
                pop     = cpu_eoi_i;
                capture = !cpu_eoi_i && eligible;
            end
            default: ;
        endcase
    end

    // ---- capture stage: request frozen while it is being signalled ----
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            cap_id_p0   <= '0;
            serviced_p1 <= 1'b0;
        end else begin
            serviced_p1 <= push;
            if (capture) begin
                cap_id_p0 <= irq_id_i;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (capture) begin
            cap_prio_p0 <= irq_prio_i;
        end
    end

`ifdef INTC_DISPATCH_ACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT);

    logic [TMO_W-1:0] tmo_cnt_p0;
    logic             tmo_err_p1;

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            tmo_cnt_p0 <= '0;
            tmo_err_p1 <= 1'b0;
        end else begin
            tmo_err_p1 <= tmo_fire;
            if ((state_q == S_SIGNAL) && (state_d == S_SIGNAL)) begin
                tmo_cnt_p0 <= tmo_cnt_p0 + 1'b1;
            end else begin
                tmo_cnt_p0 <= '0;
            end
        end
    end

    assign tmo_done      = (tmo_cnt_p0 == TMO_W'(ACK_TIMEOUT - 1));
    assign timeout_err_o = tmo_err_p1;
`else
    logic unused_tmo;

    assign tmo_done      = 1'b0;
    assign timeout_err_o = 1'b0;
    assign unused_tmo    = tmo_fire ^ (ACK_TIMEOUT != 0);
`endif

    logic unused_top_id;
    assign unused_top_id = ^stack_top.id;

    assign cpu_irq_id_o   = cap_id_p0;
    assign irq_serviced_o = serviced_p1;
    assign active_prio_o  = stack_empty ? '0 : stack_top.prio;
    assign nest_depth_o   = stack_depth;

endmodule

// File: tb/tb_intc_dispatch_ctrl.sv
// Directed bench for intc_dispatch_ctrl: vector table plus nesting, timeout and reset sequences.
module tb_intc_dispatch_ctrl;

    localparam int WIDTH       = 4;
    localparam int NEST_DEPTH  = 4;
    localparam int ACK_TIMEOUT = 32;
    localparam int DEPTH_W     = 3;
    localparam int NVEC        = 18;

    logic               pclk_i = 1'b0;
    logic               prst_i = 1'b0;
    logic               irq_valid_i = 1'b0;
    logic [WIDTH-1:0]   irq_id_i = '0;
    logic [WIDTH-1:0]   irq_prio_i = '0;
    logic               cpu_ack_i = 1'b0;
    logic               cpu_eoi_i = 1'b0;
    logic               irq_serviced_o;
    logic               cpu_irq_o;
    logic [WIDTH-1:0]   cpu_irq_id_o;
    logic [WIDTH-1:0]   active_prio_o;
    logic [DEPTH_W-1:0] nest_depth_o;
    logic               timeout_err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int valid;
        int id;
        int prio;
        int ack;
        int eoi;
        int e_irq;
        int e_id;
        int e_serv;
        int e_depth;
        int e_prio;
    } vec_t;

    vec_t vecs [NVEC];

    intc_dispatch_ctrl #(
        .NO_OF_PERIPHERALS (16),
        .WIDTH             (WIDTH),
        .NEST_DEPTH        (NEST_DEPTH),
        .ACK_TIMEOUT       (ACK_TIMEOUT)
    ) dut (
        .pclk_i         (pclk_i),
        .prst_i         (prst_i),
        .irq_valid_i    (irq_valid_i),
        .irq_id_i       (irq_id_i),
        .irq_prio_i     (irq_prio_i),
        .irq_serviced_o (irq_serviced_o),
        .cpu_irq_o      (cpu_irq_o),
        .cpu_irq_id_o   (cpu_irq_id_o),
        .cpu_ack_i      (cpu_ack_i),
        .cpu_eoi_i      (cpu_eoi_i),
        .active_prio_o  (active_prio_o),
        .nest_depth_o   (nest_depth_o),
        .timeout_err_o  (timeout_err_o)
    );

    initial begin
        forever #5 pclk_i = ~pclk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cpu_irq"}, int'(cpu_irq_o), 0);
        check({tag, " cpu_irq_id"}, int'(cpu_irq_id_o), 0);
        check({tag, " serviced"}, int'(irq_serviced_o), 0);
        check({tag, " depth"}, int'(nest_depth_o), 0);
        check({tag, " active_prio"}, int'(active_prio_o), 0);
        check({tag, " timeout_err"}, int'(timeout_err_o), 0);
    endtask

    initial begin
        int n;
        int exp_prio [4];

        //             valid id prio ack eoi | irq id serv depth aprio
        vecs[0]  = '{1, 5,  3, 0, 0, 1, 5, 0, 0, 0};
        vecs[1]  = '{1, 5,  3, 0, 0, 1, 5, 0, 0, 0};
        vecs[2]  = '{1, 5,  3, 0, 0, 1, 5, 0, 0, 0};
        vecs[3]  = '{0, 0,  0, 1, 0, 0, 0, 1, 1, 3};
        vecs[4]  = '{0, 0,  0, 0, 0, 0, 0, 0, 1, 3};
        vecs[5]  = '{0, 0,  0, 0, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0,  0, 1, 1, 0, 0, 0, 0, 0};
        vecs[7]  = '{1, 2,  4, 0, 0, 1, 2, 0, 0, 0};
        vecs[8]  = '{0, 0,  0, 1, 0, 0, 0, 1, 1, 4};
        vecs[9]  = '{1, 9, 10, 0, 0, 1, 9, 0, 1, 4};
        vecs[10] = '{1, 7, 12, 0, 0, 1, 9, 0, 1, 4};
        vecs[11] = '{0, 0,  0, 1, 0, 0, 0, 1, 2, 10};
        vecs[12] = '{0, 0,  0, 0, 1, 0, 0, 0, 1, 4};
        vecs[13] = '{1, 3,  4, 0, 0, 0, 0, 0, 1, 4};
        vecs[14] = '{1, 3,  4, 0, 1, 0, 0, 0, 0, 0};
        vecs[15] = '{1, 3,  4, 0, 0, 1, 3, 0, 0, 0};
        vecs[16] = '{0, 0,  0, 1, 0, 0, 0, 1, 1, 4};
        vecs[17] = '{0, 0,  0, 0, 1, 0, 0, 0, 0, 0};

        #20;
        check_all_zero("reset");
        #10;
        prst_i = 1'b1;
        step();
        check_all_zero("post_reset");

        for (int i = 0; i < NVEC; i++) begin
            irq_valid_i = 1'(vecs[i].valid);
            irq_id_i    = WIDTH'(vecs[i].id);
            irq_prio_i  = WIDTH'(vecs[i].prio);
            cpu_ack_i   = 1'(vecs[i].ack);
            cpu_eoi_i   = 1'(vecs[i].eoi);
            step();
            check($sformatf("vec%0d cpu_irq", i), int'(cpu_irq_o), vecs[i].e_irq);
            if (vecs[i].e_irq != 0) begin
                check($sformatf("vec%0d cpu_irq_id", i), int'(cpu_irq_id_o), vecs[i].e_id);
            end
            check($sformatf("vec%0d serviced", i), int'(irq_serviced_o), vecs[i].e_serv);
            check($sformatf("vec%0d depth", i), int'(nest_depth_o), vecs[i].e_depth);
            check($sformatf("vec%0d active_prio", i), int'(active_prio_o), vecs[i].e_prio);
            check($sformatf("vec%0d timeout_err", i), int'(timeout_err_o), 0);
        end
        irq_valid_i = 1'b0;
        cpu_ack_i   = 1'b0;
        cpu_eoi_i   = 1'b0;

        // Fill the stack with rising priorities, then a top-priority request must wait.
        for (int k = 0; k < NEST_DEPTH; k++) begin
            irq_valid_i = 1'b1;
            irq_id_i    = WIDTH'(k + 1);
            irq_prio_i  = WIDTH'(k + 1);
            step();
            check($sformatf("fill%0d cpu_irq", k), int'(cpu_irq_o), 1);
            irq_valid_i = 1'b0;
            cpu_ack_i   = 1'b1;
            step();
            cpu_ack_i   = 1'b0;
            check($sformatf("fill%0d depth", k), int'(nest_depth_o), k + 1);
            check($sformatf("fill%0d serviced", k), int'(irq_serviced_o), 1);
        end
        check("full active_prio", int'(active_prio_o), NEST_DEPTH);
        irq_valid_i = 1'b1;
        irq_id_i    = 4'd15;
        irq_prio_i  = 4'd15;
        for (int j = 0; j < 5; j++) begin
            step();
            check($sformatf("full_wait%0d cpu_irq", j), int'(cpu_irq_o), 0);
        end
        cpu_eoi_i = 1'b1;
        step();
        cpu_eoi_i = 1'b0;
        check("full_eoi depth", int'(nest_depth_o), 3);
        check("full_eoi cpu_irq", int'(cpu_irq_o), 0);
        step();
        check("full_after cpu_irq", int'(cpu_irq_o), 1);
        check("full_after cpu_irq_id", int'(cpu_irq_id_o), 15);
        irq_valid_i = 1'b0;
        cpu_ack_i   = 1'b1;
        step();
        cpu_ack_i   = 1'b0;
        check("full_refill depth", int'(nest_depth_o), 4);
        check("full_refill active_prio", int'(active_prio_o), 15);
        exp_prio = '{3, 2, 1, 0};
        for (int k = 0; k < 4; k++) begin
            cpu_eoi_i = 1'b1;
            step();
            check($sformatf("drain%0d active_prio", k), int'(active_prio_o), exp_prio[k]);
            check($sformatf("drain%0d depth", k), int'(nest_depth_o), 3 - k);
        end
        cpu_eoi_i = 1'b0;

`ifdef INTC_DISPATCH_ACK_TIMEOUT_EN
        irq_valid_i = 1'b1;
        irq_id_i    = 4'd4;
        irq_prio_i  = 4'd5;
        step();
        irq_valid_i = 1'b0;
        n = 0;
        while (cpu_irq_o === 1'b1 && n < 100) begin
            check($sformatf("tmo_wait%0d timeout_err", n), int'(timeout_err_o), 0);
            check($sformatf("tmo_wait%0d serviced", n), int'(irq_serviced_o), 0);
            n++;
            step();
        end
        check("tmo cpu_irq_cycles", n, ACK_TIMEOUT);
        check("tmo timeout_err", int'(timeout_err_o), 1);
        check("tmo serviced", int'(irq_serviced_o), 0);
        check("tmo depth", int'(nest_depth_o), 0);
        step();
        check("tmo_after timeout_err", int'(timeout_err_o), 0);
        check("tmo_after cpu_irq", int'(cpu_irq_o), 0);

        irq_valid_i = 1'b1;
        irq_id_i    = 4'd6;
        irq_prio_i  = 4'd7;
        step();
        irq_valid_i = 1'b0;
        repeat (ACK_TIMEOUT - 1) step();
        check("tmo_ack_terminal cpu_irq", int'(cpu_irq_o), 1);
        cpu_ack_i = 1'b1;
        step();
        cpu_ack_i = 1'b0;
        check("tmo_ack serviced", int'(irq_serviced_o), 1);
        check("tmo_ack timeout_err", int'(timeout_err_o), 0);
        check("tmo_ack depth", int'(nest_depth_o), 1);
        check("tmo_ack cpu_irq", int'(cpu_irq_o), 0);
        step();
        check("tmo_ack_after timeout_err", int'(timeout_err_o), 0);
`else
        irq_valid_i = 1'b1;
        irq_id_i    = 4'd6;
        irq_prio_i  = 4'd7;
        step();
        irq_valid_i = 1'b0;
        n = 0;
        for (int j = 0; j < 40; j++) begin
            if (cpu_irq_o === 1'b1 && timeout_err_o === 1'b0) n++;
            step();
        end
        check("noack cycles_held", n, 40);
        check("noack cpu_irq", int'(cpu_irq_o), 1);
        cpu_ack_i = 1'b1;
        step();
        cpu_ack_i = 1'b0;
        check("noack_ack serviced", int'(irq_serviced_o), 1);
        check("noack_ack depth", int'(nest_depth_o), 1);
`endif
        cpu_eoi_i = 1'b1;
        step();
        cpu_eoi_i = 1'b0;
        check("tmo_cleanup depth", int'(nest_depth_o), 0);

        // Reset while signalling a third request with two entries in service.
        for (int k = 0; k < 2; k++) begin
            irq_valid_i = 1'b1;
            irq_id_i    = WIDTH'(k + 1);
            irq_prio_i  = WIDTH'(k + 1);
            step();
            irq_valid_i = 1'b0;
            cpu_ack_i   = 1'b1;
            step();
            cpu_ack_i   = 1'b0;
        end
        irq_valid_i = 1'b1;
        irq_id_i    = 4'd3;
        irq_prio_i  = 4'd3;
        step();
        irq_valid_i = 1'b0;
        check("rst_pre cpu_irq", int'(cpu_irq_o), 1);
        check("rst_pre depth", int'(nest_depth_o), 2);
        #2;
        prst_i = 1'b0;
        #1;
        check_all_zero("rst_async");
        step();
        prst_i = 1'b1;
        step();
        check_all_zero("rst_release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
